// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter granting one shared resource to one of 16 requesters.
// Optional macro ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES BUSY cycles.
module rr_arbiter_16 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [15:0]          req,
    input  logic                 ack,
    output logic [15:0]          grant,
    output logic [3:0]           select,
    output logic                 busy,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] done_count
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter_16: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          grant_q, grant_d;
    logic [3:0]           select_q, select_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] done_q, done_d;

    logic                 found;
    logic [3:0]           win_idx;
    logic [3:0]           cand;

    // Scan ptr, ptr+1, ... wrapping mod 16; the first set request wins.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        done_d   = done_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = 8'd0;
`endif
                if (found) begin
                    state_d  = S_BUSY;
                    grant_d  = 16'(1) << win_idx;
                    select_d = win_idx;
                end
            end
            S_BUSY: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = hold_q + 8'd1;
`endif
                // ack wins over a simultaneous req drop or hold-limit hit.
                if (ack) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = select_q + 4'd1;
                    done_d  = done_q + CNT_WIDTH'(1);
                end else if (!req[select_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = select_q + 4'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    ptr_d     = select_q + 4'd1;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            select_q <= '0;
            ptr_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant      = grant_q;
    assign select     = select_q;
    assign busy       = (state_q == S_BUSY);
    assign done_count = done_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: expected grant order is queued as stimulus is
// applied and compared as each grant appears.
module tb_rr_arbiter_16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        ack;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        busy;
    logic        timeout;
    logic [15:0] done_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    rr_arbiter_16 #(
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .grant     (grant),
        .select    (select),
        .busy      (busy),
        .timeout   (timeout),
        .done_count(done_count)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for busy; n = cycles waited.
    task automatic wait_busy(output int n);
        n = 0;
        while (!busy && n < 64) begin
            cyc();
            n++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        ack   = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n, e;
        reset = 1'b1;
        req   = 16'hFFFF;
        ack   = 1'b0;
        cyc();
        checks++;
        if (grant !== 16'h0 || select !== 4'd0 || busy !== 1'b0 || timeout !== 1'b0 || done_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_init: grant=%h select=%0d busy=%b timeout=%b done=%0d, expected all zero",
                     grant, select, busy, timeout, done_count);
        end
        reset = 1'b0;
        exp_q = {0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            wait_busy(n);
            e = exp_q.pop_front();
            checks++;
            if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
                errors++;
                $display("FAIL reset_pre_grant: busy=%b grant=%h select=%0d, expected grant=%h select=%0d",
                         busy, grant, select, 16'h0001 << e, e);
            end
            if (k < 2) begin
                ack = 1'b1;
                cyc();
                ack = 1'b0;
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 16'h0 || select !== 4'd0 || busy !== 1'b0 || done_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: grant=%h select=%0d busy=%b done=%0d, expected all zero",
                     grant, select, busy, done_count);
        end
        cyc();
        reset = 1'b0;
        exp_q.push_back(0);
        wait_busy(n);
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
            errors++;
            $display("FAIL reset_first_grant: busy=%b grant=%h select=%0d, expected grant=%h select=%0d",
                     busy, grant, select, 16'h0001 << e, e);
        end
        req = '0;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    task automatic test_rotation();
        int n, e, exp_done;
        apply_reset();
        exp_done = 0;
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) exp_q.push_back(i % 16);
        for (int i = 0; i < 17; i++) begin
            wait_busy(n);
            e = exp_q.pop_front();
            checks++;
            if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: busy=%b grant=%h select=%0d, expected grant=%h select=%0d",
                         i, busy, grant, select, 16'h0001 << e, e);
            end
            if (i > 0) begin
                checks++;
                if (n !== 1) begin
                    errors++;
                    $display("FAIL rotation_turnaround[%0d]: idle cycles=%0d, expected 1", i, n);
                end
            end
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            exp_done++;
            checks++;
            if (grant !== 16'h0 || busy !== 1'b0 || done_count !== 16'(exp_done)) begin
                errors++;
                $display("FAIL rotation_release[%0d]: grant=%h busy=%b done=%0d, expected grant=0 busy=0 done=%0d",
                         i, grant, busy, done_count, exp_done);
            end
            if (i == 15) begin
                checks++;
                if (done_count !== 16'd16) begin
                    errors++;
                    $display("FAIL rotation_count16: done=%0d, expected 16", done_count);
                end
            end
        end
        req = '0;
        cyc();
    endtask

    task automatic test_two_party();
        int n, e;
        apply_reset();
        req = 16'h8001;
        exp_q = {0, 15, 0, 15};
        for (int i = 0; i < 4; i++) begin
            wait_busy(n);
            e = exp_q.pop_front();
            checks++;
            if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
                errors++;
                $display("FAIL two_party_grant[%0d]: busy=%b grant=%h select=%0d, expected grant=%h select=%0d",
                         i, busy, grant, select, 16'h0001 << e, e);
            end
            req = 16'h8FF1;
            cyc();
            checks++;
            if (busy !== 1'b1 || grant !== (16'h0001 << e)) begin
                errors++;
                $display("FAIL two_party_stable[%0d]: busy=%b grant=%h, expected grant=%h",
                         i, busy, grant, 16'h0001 << e);
            end
            req = 16'h8001;
            ack = 1'b1;
            cyc();
            ack = 1'b0;
        end
        req = '0;
        cyc();
    endtask

    task automatic test_early_drop();
        int n, e;
        apply_reset();
        req = 16'h00E0;
        exp_q = {5, 6, 7};
        wait_busy(n);
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
            errors++;
            $display("FAIL drop_grant5: grant=%h select=%0d, expected grant=%h", grant, select, 16'h0001 << e);
        end
        req = 16'h00C0;
        cyc();
        checks++;
        if (grant !== 16'h0 || busy !== 1'b0 || done_count !== 16'd0) begin
            errors++;
            $display("FAIL drop_release: grant=%h busy=%b done=%0d, expected grant=0 busy=0 done=0",
                     grant, busy, done_count);
        end
        wait_busy(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== 1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
            errors++;
            $display("FAIL drop_next_grant: idle=%0d grant=%h select=%0d, expected idle=1 grant=%h",
                     n, grant, select, 16'h0001 << e);
        end
        req = 16'h0080;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || done_count !== 16'd1) begin
            errors++;
            $display("FAIL drop_with_ack: busy=%b done=%0d, expected busy=0 done=1", busy, done_count);
        end
        wait_busy(n);
        e = exp_q.pop_front();
        checks++;
        if (select !== e[3:0] || grant !== (16'h0001 << e)) begin
            errors++;
            $display("FAIL drop_grant7: grant=%h select=%0d, expected grant=%h", grant, select, 16'h0001 << e);
        end
        req = '0;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    task automatic test_wrap();
        int n, e;
        apply_reset();
        ack = 1'b1;
        cyc();
        cyc();
        ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant !== 16'h0 || done_count !== 16'd0) begin
            errors++;
            $display("FAIL idle_ack: busy=%b grant=%h done=%0d, expected all zero", busy, grant, done_count);
        end
        req = 16'h2000;
        exp_q = {13, 0, 2};
        for (int i = 0; i < 3; i++) begin
            wait_busy(n);
            e = exp_q.pop_front();
            checks++;
            if (busy !== 1'b1 || select !== e[3:0] || grant !== (16'h0001 << e)) begin
                errors++;
                $display("FAIL wrap_grant[%0d]: busy=%b grant=%h select=%0d, expected grant=%h select=%0d",
                         i, busy, grant, select, 16'h0001 << e, e);
            end
            req = (i == 2) ? 16'h0000 : 16'h0005;
            ack = 1'b1;
            cyc();
            ack = 1'b0;
        end
        checks++;
        if (done_count !== 16'd3) begin
            errors++;
            $display("FAIL wrap_count: done=%0d, expected 3", done_count);
        end
    endtask

    task automatic test_timeout();
        int n, nb, bad;
        apply_reset();
        req = 16'h0010;
        wait_busy(n);
        checks++;
        if (busy !== 1'b1 || grant !== 16'h0010) begin
            errors++;
            $display("FAIL timeout_grant: busy=%b grant=%h, expected grant=0010", busy, grant);
        end
`ifdef ARB_TIMEOUT_EN
        nb = 1;
        while (busy && nb < 50) begin
            cyc();
            if (busy) nb++;
        end
        checks++;
        if (nb !== 4 || timeout !== 1'b1 || grant !== 16'h0 || done_count !== 16'd0) begin
            errors++;
            $display("FAIL timeout_release: busy_cycles=%0d timeout=%b grant=%h done=%0d, expected 4 1 0000 0",
                     nb, timeout, grant, done_count);
        end
        cyc();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: timeout=%b busy=%b, expected timeout=0 busy=1", timeout, busy);
        end
        cyc();
        cyc();
        cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b0 || done_count !== 16'd1) begin
            errors++;
            $display("FAIL timeout_ack_wins: busy=%b timeout=%b done=%0d, expected 0 0 1", busy, timeout, done_count);
        end
        req = '0;
        cyc();
`else
        nb  = 0;
        bad = 0;
        repeat (120) begin
            cyc();
            nb++;
            if (grant !== 16'h0010 || timeout !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_forever: %0d of %0d cycles lost grant or pulsed timeout, expected 0", bad, nb);
        end
        req = '0;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        ack   = 1'b0;
        test_reset();
        test_rotation();
        test_two_party();
        test_early_drop();
        test_wrap();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
